hpi_access_ctrl: RTL

// - Upstream sequencer for the HPI I/O interface stage.
// - Turns single-word read/write requests (from the NIOS-side bridge or a HW master) into timed

---
 rtl/hpi_access_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hpi_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hpi_access_ctrl: sequences single-word HPI accesses into timed strobes.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hpi_access_ctrl #(
   parameter int STROBE_CYCLES  = 4,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_done,
   output logic [15:0] rsp_rdata,
   output logic [1:0]  from_sw_address,
   output logic [15:0] from_sw_data_out,
   output logic        from_sw_r,
   output logic        from_sw_w,
   output logic        from_sw_cs,
   input  logic [15:0] from_sw_data_in
);

   localparam int c_max_cycles = (STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES : RECOVER_CYCLES;
   localparam int c_cw         = $clog2(c_max_cycles);
   localparam logic [c_cw-1:0] c_strobe_load  = c_cw'(STROBE_CYCLES - 1);
   localparam logic [c_cw-1:0] c_recover_load = c_cw'(RECOVER_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STROBE  = 3'd2,
      S_HOLD    = 3'd3,
      S_RECOVER = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [c_cw-1:0]  r_cnt;
   logic [c_cw-1:0]  w_cnt_nxt;
   logic             r_we;
   logic [1:0]       r_addr;
   logic [15:0]      r_wdata;
   logic [15:0]      r_rdata;
   logic             r_cs;
   logic             r_rd;
   logic             r_wr;
   logic             r_done;
   logic             w_accept;
   logic             w_we_nxt;
   logic             w_cs_nxt;
   logic             w_rd_nxt;
   logic             w_wr_nxt;
   logic             w_done_nxt;
   logic             w_capture;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            w_state_nxt = S_STROBE;
            w_cnt_nxt   = c_strobe_load;
         end
         S_STROBE: begin
            if (r_cnt == '0) w_state_nxt = S_HOLD;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         S_HOLD: begin
            w_state_nxt = S_RECOVER;
            w_cnt_nxt   = c_recover_load;
         end
         S_RECOVER: begin
            if (r_cnt == '0) w_state_nxt = S_IDLE;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Strobes are registered from the next state so they change cleanly on the edge.
      w_we_nxt   = w_accept ? req_we : r_we;
      w_cs_nxt   = !(w_state_nxt inside {S_SETUP, S_STROBE, S_HOLD});
      w_rd_nxt   = !((w_state_nxt == S_STROBE) && !w_we_nxt);
      w_wr_nxt   = !((w_state_nxt == S_STROBE) &&  w_we_nxt);
      w_done_nxt = (r_state == S_RECOVER) && (r_cnt == '0);
      w_capture  = (r_state == S_STROBE) && (r_cnt == '0) && !r_we;
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cs    <= 1'b1;
         r_rd    <= 1'b1;
         r_wr    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         r_cs   <= w_cs_nxt;
         r_rd   <= w_rd_nxt;
         r_wr   <= w_wr_nxt;
         r_done <= w_done_nxt;
         // Last strobe edge: data has passed both interface registers by now.
         if (w_capture) r_rdata <= from_sw_data_in;
      end
   end

   assign req_ready        = (r_state == S_IDLE);
   assign rsp_done         = r_done;
   assign rsp_rdata        = r_rdata;
   assign from_sw_address  = r_addr;
   assign from_sw_data_out = r_wdata;
   assign from_sw_r        = r_rd;
   assign from_sw_w        = r_wr;
   assign from_sw_cs       = r_cs;

endmodule
`default_nettype wire
